// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: RV32I opcode
// classes, forwarding-select encodings and the controller state type.
package hazard_ctrl_pkg;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;
  localparam logic [6:0] OPC_CSR       = 7'b1110011;

  // X-stage operand select encodings
  localparam logic [1:0] FWD_RF = 2'b00;  // register file value
  localparam logic [1:0] FWD_M  = 2'b01;  // result now in M
  localparam logic [1:0] FWD_W  = 2'b10;  // result now in W

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_FLUSH    = 2'b01,
    ST_CSR_WAIT = 2'b10
  } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_src_use_decode.sv
// Combinational source-register decode for the instruction in D: extracts
// rs1/rs2 and reports which of them the instruction actually reads.
module src_use_decode
  import hazard_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] inst,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic             uses_rs1,
  output logic             uses_rs2,
  output logic             is_csr
);

  logic [6:0] opcode;
  logic       funct3_msb;
  logic       unused_bits;

  assign opcode     = inst[6:0];
  assign funct3_msb = inst[14];
  assign rs1        = inst[19:15];
  assign rs2        = inst[24:20];

  // rd, low funct3 bits and funct7 play no part in hazard detection
  assign unused_bits = ^{inst[WIDTH-1:25], inst[13:7]};

  // Classify opcode into source usage; immediate forms of CSR ops
  // carry a zero-extended immediate in the rs1 field.
  always_comb begin
    is_csr   = (opcode == OPC_CSR);
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    if ((opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL)) begin
      uses_rs1 = 1'b0;
    end
    if ((opcode == OPC_CSR) && funct3_msb) begin
      uses_rs1 = 1'b0;
    end
    if ((opcode == OPC_ARI_RTYPE) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH)) begin
      uses_rs2 = 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32I core. Detects load-use
// hazards and CSR serialization needs for the instruction in D, squashes
// after redirects, registers X-stage forwarding selects, and counts stall
// and flush cycles.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     inst_d,
  input  logic                 valid_d,
  input  logic                 valid_x,
  input  logic                 valid_m,
  input  logic [4:0]           rd_x,
  input  logic [4:0]           rd_m,
  input  logic                 regwen_x,
  input  logic                 regwen_m,
  input  logic                 memread_x,
  input  logic                 redirect_x,
  output logic                 stall_f,
  output logic                 stall_d,
  output logic                 flush_d,
  output logic                 bubble_x,
  output logic [1:0]           fwd_a_x,
  output logic [1:0]           fwd_b_x,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  hz_state_e state_q, state_d;

  logic [4:0] rs1, rs2;
  logic       uses_rs1, uses_rs2, is_csr;

  logic [4:0] src      [2];
  logic       src_live [2];
  logic       hit_x    [2];
  logic       hit_m    [2];
  logic [1:0] fwd_d    [2];
  logic [1:0] fwd_q    [2];

  logic x_writes, m_writes, load_use;
  logic stall_c, flush_c, bubble_c;

  logic [CNT_WIDTH-1:0] stall_cnt_q, flush_cnt_q;

  src_use_decode #(.WIDTH(WIDTH)) u_decode (
    .inst     (inst_d),
    .rs1      (rs1),
    .rs2      (rs2),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2),
    .is_csr   (is_csr)
  );

  assign src[0] = rs1;
  assign src[1] = rs2;

  assign x_writes = regwen_x && (rd_x != 5'd0);
  assign m_writes = regwen_m && (rd_m != 5'd0);

  // Per-operand match logic and next forwarding select; X wins over M
  // because it holds the younger producer.
  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    assign src_live[gi] = valid_d && (src[gi] != 5'd0) &&
                          ((gi == 0) ? uses_rs1 : uses_rs2);
    assign hit_x[gi]    = src_live[gi] && x_writes && (src[gi] == rd_x);
    assign hit_m[gi]    = src_live[gi] && m_writes && (src[gi] == rd_m);
    assign fwd_d[gi]    = bubble_c  ? FWD_RF :
                          hit_x[gi] ? FWD_M  :
                          hit_m[gi] ? FWD_W  : FWD_RF;
  end

  assign load_use = valid_x && memread_x && (hit_x[0] || hit_x[1]);

  // Next-state and control outputs; reset forces the squash pattern.
  always_comb begin
    state_d  = state_q;
    stall_c  = 1'b0;
    flush_c  = 1'b0;
    bubble_c = 1'b0;
    if (rst) begin
      flush_c  = 1'b1;
      bubble_c = 1'b1;
      state_d  = ST_FLUSH;
    end else begin
      unique case (state_q)
        ST_FLUSH: begin
          flush_c  = 1'b1;
          bubble_c = 1'b1;
          state_d  = redirect_x ? ST_FLUSH : ST_RUN;
        end
        ST_RUN: begin
          if (redirect_x) begin
            flush_c  = 1'b1;
            bubble_c = 1'b1;
            state_d  = ST_FLUSH;
          end else if (load_use) begin
            stall_c  = 1'b1;
            bubble_c = 1'b1;
          end else if (valid_d && is_csr && (valid_x || valid_m)) begin
            stall_c  = 1'b1;
            bubble_c = 1'b1;
            state_d  = ST_CSR_WAIT;
          end
        end
        ST_CSR_WAIT: begin
          if (redirect_x) begin
            flush_c  = 1'b1;
            bubble_c = 1'b1;
            state_d  = ST_FLUSH;
          end else if (valid_x || valid_m) begin
            stall_c  = 1'b1;
            bubble_c = 1'b1;
          end else begin
            state_d  = ST_RUN;
          end
        end
        default: begin
          flush_c  = 1'b1;
          bubble_c = 1'b1;
          state_d  = ST_FLUSH;
        end
      endcase
    end
  end

  // State, forwarding selects and performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FLUSH;
      fwd_q[0]    <= FWD_RF;
      fwd_q[1]    <= FWD_RF;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fwd_q[0]    <= fwd_d[0];
      fwd_q[1]    <= fwd_d[1];
      stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(stall_c);
      flush_cnt_q <= flush_cnt_q + CNT_WIDTH'(flush_c);
    end
  end

  assign stall_f   = stall_c;
  assign stall_d   = stall_c;
  assign flush_d   = flush_c;
  assign bubble_x  = bubble_c;
  assign fwd_a_x   = fwd_q[0];
  assign fwd_b_x   = fwd_q[1];
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vectors, hand-written
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_hazard_ctrl;

  localparam int W  = 32;
  localparam int CW = 4;   // narrow counters so wrap-around is exercised

  localparam logic [6:0] O_LUI = 7'b0110111, O_AUIPC = 7'b0010111, O_JAL = 7'b1101111;
  localparam logic [6:0] O_JALR = 7'b1100111, O_BR = 7'b1100011, O_LD = 7'b0000011;
  localparam logic [6:0] O_ST = 7'b0100011, O_R = 7'b0110011, O_I = 7'b0010011;
  localparam logic [6:0] O_CSR = 7'b1110011;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  inst_d;
  logic          valid_d, valid_x, valid_m;
  logic [4:0]    rd_x, rd_m;
  logic          regwen_x, regwen_m, memread_x, redirect_x;
  logic          stall_f, stall_d, flush_d, bubble_x;
  logic [1:0]    fwd_a_x, fwd_b_x;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int n_cmp = 0;
  int n_err = 0;

  hazard_ctrl #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .inst_d(inst_d), .valid_d(valid_d),
    .valid_x(valid_x), .valid_m(valid_m), .rd_x(rd_x), .rd_m(rd_m),
    .regwen_x(regwen_x), .regwen_m(regwen_m), .memread_x(memread_x),
    .redirect_x(redirect_x), .stall_f(stall_f), .stall_d(stall_d),
    .flush_d(flush_d), .bubble_x(bubble_x), .fwd_a_x(fwd_a_x),
    .fwd_b_x(fwd_b_x), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // {stall_f, stall_d, flush_d, bubble_x}
  function automatic logic [3:0] ctl();
    return {stall_f, stall_d, flush_d, bubble_x};
  endfunction

  function automatic logic [31:0] enc_r(input int rd, input int r1, input int r2);
    return {7'd0, 5'(r2), 5'(r1), 3'b000, 5'(rd), O_R};
  endfunction
  function automatic logic [31:0] enc_lw(input int rd, input int r1);
    return {12'd0, 5'(r1), 3'b010, 5'(rd), O_LD};
  endfunction
  function automatic logic [31:0] enc_csr(input int rd, input int r1, input logic imm);
    return {12'h300, 5'(r1), imm, 2'b01, 5'(rd), O_CSR};
  endfunction

  task automatic drive(input logic [31:0] inst, input logic vd, input logic vx, input logic vm,
                       input int rdx, input int rdm, input logic wx, input logic wm,
                       input logic mr, input logic rdr);
    inst_d = inst; valid_d = vd; valid_x = vx; valid_m = vm;
    rd_x = 5'(rdx); rd_m = 5'(rdm); regwen_x = wx; regwen_m = wm;
    memread_x = mr; redirect_x = rdr;
  endtask

  task automatic idle();
    drive(32'h13, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Reset for two cycles, then the post-reset FLUSH cycle; ends at a
  // negedge in RUN with flush_cnt=1 and stall_cnt=0.
  task automatic do_reset();
    @(negedge clk);
    idle(); rst = 1'b1;
    #1 chk("rst_ctl", 32'(ctl()), 32'b0011);
    @(negedge clk);
    #1 chk("rst_regs", {20'd0, fwd_a_x, fwd_b_x, stall_cnt, flush_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("post_rst_flush", 32'(ctl()), 32'b0011);
    chk("post_rst_cnt", {24'd0, stall_cnt, flush_cnt}, 32'd0);
    @(negedge clk);
    #1 chk("post_rst_run", 32'(ctl()), 32'b0000);
    chk("post_rst_flushcnt", 32'(flush_cnt), 32'd1);
  endtask

  typedef struct {
    logic [31:0] inst;
    logic vd, vx, vm;
    int   rdx, rdm;
    logic wx, wm, mr;
    logic exp_stall;
    logic [1:0] exp_fa, exp_fb;
  } vec_t;

  vec_t vecs[$];

  // Behavioural reference for the randomized run
  int          m_mode;   // 0 running, 1 squash cycle, 2 waiting for CSR drain
  logic [1:0]  m_fa, m_fb;
  int          m_sc, m_fc;

  function automatic void src_info(input logic [31:0] inst, input logic vd,
                                   output logic [4:0] s1, output logic [4:0] s2,
                                   output logic u1, output logic u2, output logic csr);
    logic [6:0] op;
    op  = inst[6:0];
    s1  = inst[19:15];
    s2  = inst[24:20];
    csr = (op == O_CSR);
    u1  = vd && (s1 != 0) && !(op inside {O_LUI, O_AUIPC, O_JAL}) && !(csr && inst[14]);
    u2  = vd && (s2 != 0) && (op inside {O_R, O_ST, O_BR});
  endfunction

  function automatic logic [1:0] pick(input logic u, input logic [4:0] s);
    if (u && regwen_x && rd_x != 0 && s == rd_x) return 2'b01;
    if (u && regwen_m && rd_m != 0 && s == rd_m) return 2'b10;
    return 2'b00;
  endfunction

  logic [6:0] opc_pool [11];

  initial begin
    logic [4:0] s1, s2;
    logic u1, u2, csr, lu, e_st, e_fl, e_bu;
    int nxt;
    logic [31:0] r;

    rst = 1'b1;
    idle();

    // ---------------- directed vectors ----------------
    vecs.push_back('{enc_r(1,3,3), 1,1,1, 3,3, 1,1,0, 0, 2'b01, 2'b01}); // X beats M
    vecs.push_back('{enc_r(1,3,3), 1,1,1, 0,0, 1,1,0, 0, 2'b00, 2'b00}); // rd=0 never forwards
    vecs.push_back('{enc_r(1,4,3), 1,1,1, 3,4, 1,1,0, 0, 2'b10, 2'b01});
    vecs.push_back('{enc_r(1,2,5), 1,1,0, 5,0, 1,0,1, 1, 2'b00, 2'b00}); // load-use on rs2
    vecs.push_back('{{12'd7,5'd5,3'b000,5'd1,O_I}, 1,1,0, 7,0, 1,0,1, 0, 2'b00, 2'b00}); // addi: rs2 field ignored
    vecs.push_back('{{7'd0,5'd0,5'd7,3'd0,5'd1,O_LUI}, 1,1,0, 7,0, 1,0,1, 0, 2'b00, 2'b00}); // lui: no rs1
    vecs.push_back('{enc_r(1,5,5), 0,1,0, 5,0, 1,0,1, 0, 2'b00, 2'b00}); // valid_d=0
    vecs.push_back('{enc_r(1,0,0), 1,1,0, 0,0, 1,0,1, 0, 2'b00, 2'b00}); // x0 sources
    vecs.push_back('{enc_csr(1,5,1'b1), 1,0,0, 5,0, 1,0,0, 0, 2'b00, 2'b00}); // csrrwi: uimm not a source
    vecs.push_back('{enc_csr(1,5,1'b0), 1,0,0, 5,0, 1,0,0, 0, 2'b01, 2'b00}); // csrrw reads rs1
    vecs.push_back('{{7'd0,5'd5,5'd6,3'b010,5'd0,O_ST}, 1,1,1, 0,5, 0,1,0, 0, 2'b00, 2'b10});
    vecs.push_back('{{7'd0,5'd7,5'd7,3'b000,5'd0,O_BR}, 1,1,0, 7,0, 1,0,0, 0, 2'b01, 2'b01});
    vecs.push_back('{enc_lw(1,5), 1,1,0, 5,0, 1,0,1, 1, 2'b00, 2'b00}); // load-use on load base
    vecs.push_back('{{12'd0,5'd5,3'd0,5'd1,O_JAL}, 1,1,0, 5,0, 1,0,1, 0, 2'b00, 2'b00});

    do_reset();
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].inst, vecs[i].vd, vecs[i].vx, vecs[i].vm, vecs[i].rdx, vecs[i].rdm,
            vecs[i].wx, vecs[i].wm, vecs[i].mr, 1'b0);
      #1 chk($sformatf("vec%0d_ctl", i), 32'(ctl()),
             {28'd0, vecs[i].exp_stall, vecs[i].exp_stall, 1'b0, vecs[i].exp_stall});
      @(posedge clk);
      #1 chk($sformatf("vec%0d_fwd", i), {28'd0, fwd_a_x, fwd_b_x}, {28'd0, vecs[i].exp_fa, vecs[i].exp_fb});
    end

    // ---------------- load-use sequence ----------------
    do_reset();
    drive(enc_r(6,5,7), 1, 1, 0, 5, 0, 1, 0, 1, 0);
    #1 chk("lu_stall", 32'(ctl()), 32'b1101);
    @(negedge clk);
    drive(enc_r(6,5,7), 1, 0, 1, 0, 5, 0, 1, 0, 0);
    #1 chk("lu_release", 32'(ctl()), 32'b0000);
    chk("lu_stallcnt", 32'(stall_cnt), 32'd1);
    @(posedge clk);
    #1 chk("lu_fwd", {28'd0, fwd_a_x, fwd_b_x}, 32'b1000);

    // ---------------- redirect beats load-use ----------------
    do_reset();
    drive(enc_r(6,5,7), 1, 1, 0, 5, 0, 1, 0, 1, 1);
    #1 chk("rd_first", 32'(ctl()), 32'b0011);
    @(negedge clk);
    drive(enc_r(6,5,7), 1, 1, 0, 5, 0, 1, 0, 1, 0);
    #1 chk("rd_flushstate", 32'(ctl()), 32'b0011);
    @(negedge clk);
    idle();
    #1 chk("rd_run", 32'(ctl()), 32'b0000);
    // one flush from the post-reset cycle plus two from the redirect
    chk("rd_flushcnt", 32'(flush_cnt), 32'd3);
    chk("rd_stallcnt", 32'(stall_cnt), 32'd0);

    // ---------------- CSR serialization ----------------
    do_reset();
    drive(enc_csr(1,3,1'b0), 1, 1, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("csr_s1", 32'(ctl()), 32'b1101);
    @(negedge clk);
    drive(enc_csr(1,3,1'b0), 1, 0, 1, 0, 0, 0, 0, 0, 0);
    #1 chk("csr_s2", 32'(ctl()), 32'b1101);
    @(negedge clk);
    drive(enc_csr(1,3,1'b0), 1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("csr_release", 32'(ctl()), 32'b0000);
    chk("csr_stallcnt", 32'(stall_cnt), 32'd2);
    @(negedge clk);
    drive(enc_r(1,2,3), 1, 1, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("csr_after", 32'(ctl()), 32'b0000);

    // ---------------- redirect during CSR wait ----------------
    do_reset();
    drive(enc_csr(1,3,1'b0), 1, 1, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("csrw_enter", 32'(ctl()), 32'b1101);
    @(negedge clk);
    drive(enc_csr(1,3,1'b0), 1, 1, 0, 0, 0, 0, 0, 0, 1);
    #1 chk("csrw_kill", 32'(ctl()), 32'b0011);
    @(negedge clk);
    idle();
    #1 chk("csrw_flush", 32'(ctl()), 32'b0011);
    @(negedge clk);
    #1 chk("csrw_run", 32'(ctl()), 32'b0000);

    // ---------------- reset mid CSR wait ----------------
    drive(enc_csr(1,3,1'b0), 1, 1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("rstw_ctl", 32'(ctl()), 32'b0011);
    @(negedge clk);
    rst = 1'b0;
    drive(enc_csr(1,3,1'b0), 1, 1, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("rstw_flush", 32'(ctl()), 32'b0011);
    @(negedge clk);
    #1 chk("rstw_reenter", 32'(ctl()), 32'b1101);

    // ---------------- randomized run ----------------
    opc_pool = '{O_LUI, O_AUIPC, O_JAL, O_JALR, O_BR, O_LD, O_ST, O_R, O_I, O_CSR, 7'b1111111};
    do_reset();
    m_mode = 0; m_fa = 2'b00; m_fb = 2'b00; m_sc = 0; m_fc = 1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      r = $urandom;
      r[6:0]   = opc_pool[$urandom_range(0, 10)];
      r[19:15] = 5'($urandom_range(0, 3));
      r[24:20] = 5'($urandom_range(0, 3));
      rst = ($urandom_range(0, 199) == 0);
      drive(r, 1'($urandom), ($urandom_range(0, 2) != 0), 1'($urandom),
            $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
            1'($urandom), ($urandom_range(0, 7) == 0));
      #1;
      src_info(inst_d, valid_d, s1, s2, u1, u2, csr);
      lu = valid_x && memread_x && regwen_x && rd_x != 0 &&
           ((u1 && s1 == rd_x) || (u2 && s2 == rd_x));
      e_st = 0; e_fl = 0; e_bu = 0; nxt = m_mode;
      if (rst) begin
        e_fl = 1; e_bu = 1; nxt = 1;
      end else if (m_mode == 1) begin
        e_fl = 1; e_bu = 1; nxt = redirect_x ? 1 : 0;
      end else if (redirect_x) begin
        e_fl = 1; e_bu = 1; nxt = 1;
      end else if (m_mode == 2) begin
        if (valid_x || valid_m) begin e_st = 1; e_bu = 1; end
        else nxt = 0;
      end else if (lu) begin
        e_st = 1; e_bu = 1;
      end else if (valid_d && csr && (valid_x || valid_m)) begin
        e_st = 1; e_bu = 1; nxt = 2;
      end
      chk($sformatf("rnd%0d_ctl", cyc), 32'(ctl()), {28'd0, e_st, e_st, e_fl, e_bu});
      chk($sformatf("rnd%0d_regs", cyc), {20'd0, fwd_a_x, fwd_b_x, stall_cnt, flush_cnt},
          {20'd0, m_fa, m_fb, 4'(m_sc), 4'(m_fc)});
      if (rst) begin
        m_fa = 0; m_fb = 0; m_sc = 0; m_fc = 0;
      end else begin
        m_fa = e_bu ? 2'b00 : pick(u1, s1);
        m_fb = e_bu ? 2'b00 : pick(u2, s2);
        m_sc = (m_sc + int'(e_st)) % 16;
        m_fc = (m_fc + int'(e_fl)) % 16;
      end
      m_mode = nxt;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
